// File: rtl/mport_rr_arbiter.sv
// mport_rr_arbiter: N-port round-robin arbiter onto one as/rw/done memory port.
// A grant is held for a whole transaction. The chosen port's request fields are
// captured at grant time. A watchdog aborts transactions the memory never answers.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; scan req_as from rr_ptr and grant the first requester
// BUSY    | mem_as high with captured fields; wait for mem_done or timeout
// DONE    | one-cycle req_done (and req_err) pulse; mem_done ignored
module mport_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 255,
  parameter int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst_l,
  input  logic [NUM_PORTS-1:0]              req_as,
  input  logic [NUM_PORTS-1:0]              req_rw,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_wdata,
  output logic [DATA_W-1:0]                 req_rdata,
  output logic [NUM_PORTS-1:0]              req_done,
  output logic                              req_err,
  output logic [NUM_PORTS-1:0]              grant,
  output logic                              mem_as,
  output logic                              mem_rw,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  input  logic                              mem_done
);

  // The counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic [PTR_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [PTR_W-1:0]      gidx_q,      gidx_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [NUM_PORTS-1:0]  grant_q,     grant_d;
  logic                  mem_as_q,    mem_as_d;
  logic                  mem_rw_q,    mem_rw_d;
  logic [ADDR_W-1:0]     mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]     req_rdata_q, req_rdata_d;
  logic [NUM_PORTS-1:0]  req_done_q,  req_done_d;
  logic                  req_err_q,   req_err_d;

  logic                  sel_found;
  logic [PTR_W-1:0]      sel_idx;
  logic [PTR_W:0]        cand;
  logic                  timed_out;
  logic [PTR_W-1:0]      ptr_after;

  // Round-robin scan: first requester at or after rr_ptr, wrapping explicitly
  // at NUM_PORTS so non-power-of-two port counts never visit phantom ports.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
        cand = cand - (PTR_W+1)'(NUM_PORTS);
      end
      if (!sel_found && req_as[cand[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Watchdog compare and the pointer value that follows the current owner.
  always_comb begin
    timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    ptr_after = (gidx_q == PTR_W'(NUM_PORTS - 1)) ? '0 : gidx_q + PTR_W'(1);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    mem_as_d    = mem_as_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_rdata_d = req_rdata_q;
    req_done_d  = req_done_q;
    req_err_d   = req_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          gidx_d           = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          mem_as_d         = 1'b1;
          mem_rw_d         = req_rw[sel_idx];
          mem_addr_d       = req_addr[sel_idx];
          mem_wdata_d      = req_wdata[sel_idx];
          cnt_d            = '0;
          state_d          = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (mem_done || timed_out) begin
          // mem_done wins over a same-cycle timeout.
          req_done_d         = '0;
          req_done_d[gidx_q] = 1'b1;
          req_err_d          = !mem_done;
          req_rdata_d        = mem_done ? mem_rdata : '0;
          mem_as_d           = 1'b0;
          mem_rw_d           = 1'b0;
          mem_addr_d         = '0;
          mem_wdata_d        = '0;
          grant_d            = '0;
          rr_ptr_d           = ptr_after;
          state_d            = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        req_done_d  = '0;
        req_err_d   = 1'b0;
        req_rdata_d = '0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      mem_as_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_rdata_q <= '0;
      req_done_q  <= '0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      mem_as_q    <= mem_as_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      req_rdata_q <= req_rdata_d;
      req_done_q  <= req_done_d;
      req_err_q   <= req_err_d;
    end
  end

  assign grant     = grant_q;
  assign mem_as    = mem_as_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign req_rdata = req_rdata_q;
  assign req_done  = req_done_q;
  assign req_err   = req_err_q;

endmodule

// File: tb/tb_mport_rr_arbiter.sv
// Directed bench for mport_rr_arbiter: a 4-port instance with an 8-cycle
// watchdog against a 4-cycle memory model, plus a 3-port instance for wrap.
module tb_mport_rr_arbiter;

  logic clk;
  logic rst_l;

  // 4-port instance
  logic [3:0]        req_as, req_rw;
  logic [3:0][22:0]  req_addr;
  logic [3:0][15:0]  req_wdata;
  logic [15:0]       req_rdata;
  logic [3:0]        req_done;
  logic              req_err;
  logic [3:0]        grant;
  logic              mem_as, mem_rw;
  logic [22:0]       mem_addr;
  logic [15:0]       mem_wdata, mem_rdata;
  logic              mem_done;

  // 3-port instance
  logic [2:0]        req3_as, req3_rw;
  logic [2:0][22:0]  req3_addr;
  logic [2:0][15:0]  req3_wdata;
  logic [15:0]       req3_rdata;
  logic [2:0]        req3_done;
  logic              req3_err;
  logic [2:0]        grant3;
  logic              mem3_as, mem3_rw;
  logic [22:0]       mem3_addr;
  logic [15:0]       mem3_wdata;
  logic              mem3_done;

  int n_tests = 0;
  int n_fail  = 0;

  mport_rr_arbiter #(.NUM_PORTS(4), .ADDR_W(23), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_as(req_as), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata), .req_done(req_done), .req_err(req_err), .grant(grant),
    .mem_as(mem_as), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  mport_rr_arbiter #(.NUM_PORTS(3), .ADDR_W(23), .DATA_W(16), .TIMEOUT(0)) dut3 (
    .clk(clk), .rst_l(rst_l),
    .req_as(req3_as), .req_rw(req3_rw), .req_addr(req3_addr), .req_wdata(req3_wdata),
    .req_rdata(req3_rdata), .req_done(req3_done), .req_err(req3_err), .grant(grant3),
    .mem_as(mem3_as), .mem_rw(mem3_rw), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
    .mem_rdata(16'h0000), .mem_done(mem3_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: done pulses in the 4th cycle of mem_as (when enabled).
  logic [15:0] mem_arr [0:255];
  int          lat;
  bit          mem_en;
  always @(negedge clk) begin
    if (!rst_l || !mem_as) begin
      lat       = 0;
      mem_done  = 1'b0;
      mem_rdata = 16'h0000;
    end else begin
      lat++;
      mem_done = mem_en && (lat == 4);
      if (mem_done) begin
        if (mem_rw) mem_arr[mem_addr[7:0]] = mem_wdata;
        mem_rdata = mem_rw ? 16'h0000 : mem_arr[mem_addr[7:0]];
      end
    end
  end

  // Level-style done for the 3-port instance: follows mem3_as.
  always @(negedge clk) mem3_done = rst_l && mem3_as;

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int p, input logic rw, input logic [22:0] a, input logic [15:0] d);
    req_rw[p]    = rw;
    req_addr[p]  = a;
    req_wdata[p] = d;
    req_as[p]    = 1'b1;
  endtask

  // Waits (bounded) for a req_done pulse, counting mem_as cycles and
  // any cycle where the downstream fields or one-hotness are wrong.
  task automatic wait_done(input int limit, input logic [22:0] exp_addr,
                           input logic [15:0] exp_wdata, input logic exp_rw,
                           output logic [3:0] done, output logic err,
                           output logic [15:0] rdata, output int as_cyc,
                           output int bad);
    done = '0; err = 1'b0; rdata = '0; as_cyc = 0; bad = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (!$onehot0(grant) || !$onehot0(req_done)) bad++;
      if (mem_as) begin
        as_cyc++;
        if (mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_rw !== exp_rw) bad++;
      end
      if (req_done != 4'b0000) begin
        done  = req_done;
        err   = req_err;
        rdata = req_rdata;
        break;
      end
    end
  endtask

  logic [3:0]  d;
  logic        e;
  logic [15:0] rd;
  int          ac, bd, cnt, nseen;
  int          order4 [5] = '{0, 1, 2, 3, 0};
  int          order3 [4] = '{0, 1, 2, 0};
  int          seen3  [4];

  initial begin
    rst_l = 1'b0;
    req_as = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    req3_as = '0; req3_rw = '0; req3_addr = '0; req3_wdata = '0;
    mem_en = 1'b1;
    for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
    mem_arr[8'h10] = 16'h0005;
    for (int i = 0; i < 4; i++) mem_arr[8'h20 + i] = 16'h0100 + 16'(i);
    mem_arr[8'h41] = 16'h4141;

    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_mem_as", 32'(mem_as), 0);
    chk("rst_req_done", 32'(req_done), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst_l = 1'b1;
    @(negedge clk);

    // 3-port wrap: all ports hold requests; order must be 0,1,2,0.
    req3_as = 3'b111;
    nseen = 0;
    for (int c = 0; c < 40 && nseen < 4; c++) begin
      @(negedge clk);
      if (req3_done != 3'b000) begin
        seen3[nseen] = -1;
        for (int p = 0; p < 3; p++) if (req3_done[p]) seen3[nseen] = p;
        if (!$onehot(req3_done)) seen3[nseen] = -2;
        nseen++;
      end
    end
    req3_as = 3'b000;
    chk("wrap3_count", 32'(nseen), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap3_order%0d", i), 32'(seen3[i]), 32'(order3[i]));

    // Simultaneous requests from all four ports, reissued after each done.
    for (int p = 0; p < 4; p++) issue(p, 1'b0, 23'h20 + 23'(p), 16'h0000);
    for (int i = 0; i < 5; i++) begin
      wait_done(20, 23'h20 + 23'(order4[i]), 16'h0000, 1'b0, d, e, rd, ac, bd);
      chk($sformatf("sim_done%0d", i), 32'(d), 32'(4'b0001 << order4[i]));
      chk($sformatf("sim_rdata%0d", i), 32'(rd), 32'(16'h0100 + 16'(order4[i])));
      chk($sformatf("sim_bad%0d", i), 32'(bd), 0);
      req_as[order4[i]] = 1'b0;
      @(negedge clk);
      if (i < 4) req_as[order4[i]] = 1'b1;
    end
    req_as = '0;
    repeat (2) @(negedge clk);

    // Single read, port 1, addr 0x10.
    issue(1, 1'b0, 23'h10, 16'h1234);
    wait_done(20, 23'h10, 16'h1234, 1'b0, d, e, rd, ac, bd);
    chk("rd_done", 32'(d), 32'(4'b0010));
    chk("rd_rdata", 32'(rd), 32'h0005);
    chk("rd_err", 32'(e), 0);
    chk("rd_as_cycles", 32'(ac), 4);
    chk("rd_fields", 32'(bd), 0);
    req_as[1] = 1'b0;
    @(negedge clk);
    chk("rd_done_one_cycle", 32'(req_done), 0);
    @(negedge clk);

    // Write capture, port 2: wdata changes one cycle after grant.
    issue(2, 1'b1, 23'h7, 16'hBEEF);
    @(negedge clk);
    chk("wr_grant", 32'(grant), 32'(4'b0100));
    req_wdata[2] = 16'h0000;
    wait_done(20, 23'h7, 16'hBEEF, 1'b1, d, e, rd, ac, bd);
    chk("wr_done", 32'(d), 32'(4'b0100));
    chk("wr_as_cycles", 32'(ac), 3);
    chk("wr_stable", 32'(bd), 0);
    chk("wr_mem", 32'(mem_arr[7]), 32'hBEEF);
    req_as[2] = 1'b0;
    repeat (2) @(negedge clk);

    // Rotation: pointer now 3; ports 0 and 3 request together.
    issue(0, 1'b0, 23'h30, 16'h0000);
    issue(3, 1'b0, 23'h33, 16'h0000);
    wait_done(20, 23'h33, 16'h0000, 1'b0, d, e, rd, ac, bd);
    chk("rot_first", 32'(d), 32'(4'b1000));
    req_as[3] = 1'b0;
    wait_done(20, 23'h30, 16'h0000, 1'b0, d, e, rd, ac, bd);
    chk("rot_second", 32'(d), 32'(4'b0001));
    chk("rot_bad", 32'(bd), 0);
    req_as[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout: memory silent.
    mem_en = 1'b0;
    issue(1, 1'b0, 23'h40, 16'h0000);
    wait_done(40, 23'h40, 16'h0000, 1'b0, d, e, rd, ac, bd);
    chk("to_done", 32'(d), 32'(4'b0010));
    chk("to_err", 32'(e), 1);
    chk("to_rdata", 32'(rd), 0);
    chk("to_as_cycles", 32'(ac), 8);
    req_as[1] = 1'b0;
    mem_en = 1'b1;
    @(negedge clk);
    chk("to_err_cleared", 32'(req_err), 0);
    issue(2, 1'b0, 23'h41, 16'h0000);
    wait_done(20, 23'h41, 16'h0000, 1'b0, d, e, rd, ac, bd);
    chk("after_to_done", 32'(d), 32'(4'b0100));
    chk("after_to_err", 32'(e), 0);
    chk("after_to_rdata", 32'(rd), 32'h4141);
    req_as[2] = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the 2nd BUSY cycle; pointer must restart at 0.
    issue(1, 1'b0, 23'h50, 16'h0000);
    @(negedge clk);
    chk("mid_busy_as", 32'(mem_as), 1);
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_mem_as", 32'(mem_as), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_req_done", 32'(req_done), 0);
    req_as = '0;
    @(negedge clk);
    rst_l = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_done != 4'b0000) cnt++;
    end
    chk("no_done_after_rst", 32'(cnt), 0);
    issue(0, 1'b0, 23'h60, 16'h0000);
    issue(3, 1'b0, 23'h63, 16'h0000);
    wait_done(20, 23'h60, 16'h0000, 1'b0, d, e, rd, ac, bd);
    chk("post_rst_first", 32'(d), 32'(4'b0001));
    req_as[0] = 1'b0;
    wait_done(20, 23'h63, 16'h0000, 1'b0, d, e, rd, ac, bd);
    chk("post_rst_second", 32'(d), 32'(4'b1000));
    req_as[3] = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mport_rr_arbiter.md
Name: mport_rr_arbiter

Overview:
Parametrised N-port round-robin arbiter that multiplexes memory-port requests onto one downstream as/rw/done memory interface (SDRAM controller or m9k wrapper). Successor to the fixed-port counter-based SDRAM/m9k port mux.
- Grant is held for a whole transaction.
- Fairness is guaranteed by a rotating priority pointer.
- Request fields are captured at grant.
- A bounded-latency watchdog reports an error when memory never answers.

Parameters:
NUM_PORTS, 4, number of requesting ports (2..16)
ADDR_W, 23, address width
DATA_W, 16, data width
TIMEOUT, 255, max BUSY cycles before abort; 0 disables watchdog
PTR_W, $clog2(NUM_PORTS), pointer/grant index width (derived)

Ports:
clk  input  1  clock
rst_l  input  1  reset, asynchronous, active-low
req_as  input  NUM_PORTS  per-port request strobe, held until req_done
req_rw  input  NUM_PORTS  per-port 1=write, 0=read
req_addr  input  NUM_PORTS*ADDR_W  per-port address, packed [NUM_PORTS-1:0][ADDR_W-1:0]
req_wdata  input  NUM_PORTS*DATA_W  per-port write data
req_rdata  output  DATA_W  read data, shared, valid with req_done
req_done  output  NUM_PORTS  one-hot single-cycle completion pulse
req_err  output  1  high with req_done when transaction timed out
grant  output  NUM_PORTS  one-hot current owner, 0 when idle
mem_as  output  1  downstream address strobe
mem_rw  output  1  downstream 1=write
mem_addr  output  ADDR_W  downstream address
mem_wdata  output  DATA_W  downstream write data
mem_rdata  input  DATA_W  downstream read data, valid with mem_done
mem_done  input  1  downstream completion (pulse or level)

Behaviour:
- Reset (async, any state):
  - State=IDLE, rr_ptr=0, timeout counter=0.
  - All outputs 0.
  - An in-flight transaction is dropped: no req_done is issued, and mem_as falls asynchronously.
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - If req_as is nonzero, select the first set bit scanning rr_ptr, rr_ptr+1, … wrapping modulo NUM_PORTS.
  - Capture that port's rw/addr/wdata into mem_* regs, set grant one-hot, mem_as<=1, clear the counter, go to BUSY.
  - If req_as==0, stay in IDLE with outputs unchanged at 0.
- BUSY:
  - mem_as, mem_rw, mem_addr, mem_wdata and grant stay stable. Changes on requester inputs are ignored.
  - On mem_done=1: capture mem_rdata into req_rdata (for writes too, value don't-care), req_done[g]<=1, req_err<=0, mem_as<=0, grant<=0, rr_ptr<=(g+1) mod NUM_PORTS, go to DONE.
  - Otherwise the counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without mem_done: same exit, but req_err<=1 and req_rdata<=0.
  - mem_done takes priority over timeout in the same cycle.
- DONE:
  - req_done/req_err are high for exactly this one cycle; mem_as=0.
  - Next cycle returns to IDLE and clears req_done/req_err. mem_done is ignored here; a level-style done may still be high.
- Requester rule: deassert req_as in the cycle after req_done is observed.
  - The arbiter samples req_as in IDLE only, at least one cycle after DONE, so a stale request from the same port is never double-served.
  - If that port still requests, it is served again only when no other port requests, because of pointer rotation.
- Latency, request → mem_as: req_as is sampled at edge k (IDLE), and mem_as is high after edge k.
  - mem_done sampled at edge m gives req_done high after edge m.
  - The next grant is possible at edge m+2.
- Requester aborts (req_as drops while granted): the transaction still completes and req_done is still pulsed.
- NUM_PORTS not a power of two: pointer wraps explicitly from NUM_PORTS-1 to 0, never via modulo-2^PTR_W.
- Only one port is ever granted; grant and req_done are one-hot or zero at all times.

Test Plan:
- Single read: port 1 reads addr 0x10; memory model with 4-cycle latency returns 0x0005 → mem_as high 4 cycles with addr 0x10 and rw=0; req_done=4'b0010 for one cycle; req_rdata=0x0005; req_err=0.
- Simultaneous requests: all 4 ports assert after reset (rr_ptr=0) and reissue immediately after each done → grant order 0,1,2,3,0; each req_done one-hot; no port granted twice before the others.
- Rotation and wrap: rr_ptr=3 (after serving port 2); ports 0 and 3 request → port 3 served first, then port 0; with NUM_PORTS=3 the pointer wraps 2→0.
- Write capture: port 2 writes 0xBEEF to 0x7 and changes req_wdata to 0x0000 one cycle after grant → mem_wdata stays 0xBEEF until done; memory model stores 0xBEEF.
- Timeout: TIMEOUT=8, memory never asserts mem_done → mem_as high exactly 8 cycles; req_done[g]=1 with req_err=1 and req_rdata=0; arbiter returns to IDLE; next port is served normally.
- Reset mid-BUSY: assert rst_l=0 asynchronously in cycle 2 of a transaction → mem_as, grant and req_done are 0 immediately; no req_done after release; rr_ptr=0, so port 0 wins the next contention.
